// File: rtl/pio_cfg_loader.sv
// pio_cfg_loader: expands a valid/ready command stream into timed pio
// action/index/mindex/din bus cycles, tracking program length and enable mask.
module pio_cfg_loader #(
  parameter int NUM_MACHINES = 4,
  parameter int HOLD         = 2,
  parameter int PROG_DEPTH   = 32,
  localparam int MW          = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [MW-1:0]           cmd_mach,
  input  logic [4:0]              cmd_index,
  input  logic [31:0]             cmd_data,
  output logic [3:0]              action,
  output logic [4:0]              index,
  output logic [MW-1:0]           mindex,
  output logic [31:0]             din,
  output logic                    busy,
  output logic                    err,
  output logic [5:0]              plen,
  output logic [NUM_MACHINES-1:0] en_mask
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_INSTR   = 4'd1;
  localparam logic [3:0] OP_WRAP    = 4'd2;
  localparam logic [3:0] OP_PUSH    = 4'd4;
  localparam logic [3:0] OP_PINS    = 4'd5;
  localparam logic [3:0] OP_ENABLE  = 4'd6;
  localparam logic [3:0] OP_DIV     = 4'd7;
  localparam logic [3:0] OP_SIDESET = 4'd8;
  localparam logic [3:0] OP_COMMIT  = 4'd9;
  localparam logic [3:0] OP_DISABLE = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_GAP  = 3'd2,
    ST_CW   = 3'd3,
    ST_CE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              action_q, action_d;
  logic [4:0]              index_q, index_d;
  logic [MW-1:0]           mindex_q, mindex_d;
  logic [31:0]             din_q, din_d;
  logic                    err_q, err_d;
  logic [5:0]              plen_q, plen_d;
  logic [NUM_MACHINES-1:0] en_mask_q, en_mask_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic                    mach_ok_s;
  logic                    idx_ok_s;
  logic [5:0]              idx_p1_s;
  logic [NUM_MACHINES-1:0] cmd_bit_s;
  logic [NUM_MACHINES-1:0] hold_bit_s;

  function automatic logic [NUM_MACHINES-1:0] mach_onehot(input logic [MW-1:0] m);
    logic [NUM_MACHINES-1:0] oh;
    for (int i = 0; i < NUM_MACHINES; i++) begin
      oh[i] = (m == MW'(i));
    end
    return oh;
  endfunction

  function automatic logic [31:0] mask_to_din(input logic [NUM_MACHINES-1:0] m);
    logic [31:0] w;
    w = 32'd0;
    w[NUM_MACHINES-1:0] = m;
    return w;
  endfunction

  // Range checks collapse to constants when the field width exactly covers the range.
  if (NUM_MACHINES == (1 << MW)) begin : g_mach_full
    assign mach_ok_s = 1'b1;
  end else begin : g_mach_part
    assign mach_ok_s = (int'(cmd_mach) < NUM_MACHINES);
  end

  if (PROG_DEPTH >= 32) begin : g_idx_full
    assign idx_ok_s = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_s = (int'(cmd_index) < PROG_DEPTH);
  end

  assign idx_p1_s   = {1'b0, cmd_index} + 6'd1;
  assign cmd_bit_s  = mach_onehot(cmd_mach);
  assign hold_bit_s = mach_onehot(mindex_q);

  // Next-state, next-bus and bookkeeping computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    action_d  = action_q;
    index_d   = index_q;
    mindex_d  = mindex_q;
    din_d     = din_q;
    err_d     = err_q;
    plen_d    = plen_q;
    en_mask_d = en_mask_q;
    case (state_q)
      ST_IDLE: begin
        action_d = 4'd0;
        if (cmd_valid) begin
          if (!mach_ok_s) begin
            err_d   = 1'b1;
            state_d = ST_GAP;
          end else begin
            case (cmd_op)
              OP_NOP: begin
                state_d = ST_IDLE;
              end
              OP_INSTR, OP_WRAP: begin
                if (idx_ok_s) begin
                  state_d  = ST_HOLD;
                  cnt_d    = CNT_LOAD;
                  action_d = cmd_op;
                  index_d  = cmd_index;
                  mindex_d = cmd_mach;
                  if (cmd_op == OP_INSTR) begin
                    din_d = cmd_data;
                    if (idx_p1_s > plen_q) begin
                      plen_d = idx_p1_s;
                    end else begin
                      plen_d = plen_q;
                    end
                  end else begin
                    din_d = din_q;
                  end
                end else begin
                  err_d   = 1'b1;
                  state_d = ST_GAP;
                end
              end
              // Every cycle of action=PUSH is one FIFO push, so never hold it.
              OP_PUSH: begin
                state_d  = ST_HOLD;
                cnt_d    = {CW{1'b0}};
                action_d = OP_PUSH;
                mindex_d = cmd_mach;
                din_d    = cmd_data;
              end
              OP_PINS, OP_DIV, OP_SIDESET: begin
                state_d  = ST_HOLD;
                cnt_d    = CNT_LOAD;
                action_d = cmd_op;
                mindex_d = cmd_mach;
                din_d    = cmd_data;
              end
              OP_ENABLE: begin
                state_d   = ST_HOLD;
                cnt_d     = CNT_LOAD;
                action_d  = OP_ENABLE;
                mindex_d  = cmd_mach;
                en_mask_d = en_mask_q | cmd_bit_s;
                din_d     = mask_to_din(en_mask_q | cmd_bit_s);
              end
              OP_DISABLE: begin
                state_d   = ST_HOLD;
                cnt_d     = CNT_LOAD;
                action_d  = OP_ENABLE;
                mindex_d  = cmd_mach;
                en_mask_d = en_mask_q & ~cmd_bit_s;
                din_d     = mask_to_din(en_mask_q & ~cmd_bit_s);
              end
              OP_COMMIT: begin
                if (plen_q == 6'd0) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                end else begin
                  state_d  = ST_CW;
                  cnt_d    = CNT_LOAD;
                  action_d = OP_WRAP;
                  index_d  = 5'(plen_q - 6'd1);
                  mindex_d = cmd_mach;
                end
              end
              default: begin
                err_d   = 1'b1;
                state_d = ST_GAP;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD, ST_CE: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = ST_GAP;
          action_d = 4'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      // Wrap phase done: enable the committed machine on top of the current mask.
      ST_CW: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d   = ST_CE;
          cnt_d     = CNT_LOAD;
          action_d  = OP_ENABLE;
          en_mask_d = en_mask_q | hold_bit_s;
          din_d     = mask_to_din(en_mask_q | hold_bit_s);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        state_d  = ST_IDLE;
        action_d = 4'd0;
      end
      default: begin
        state_d  = ST_IDLE;
        action_d = 4'd0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, bus and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      action_q  <= 4'd0;
      index_q   <= 5'd0;
      mindex_q  <= {MW{1'b0}};
      din_q     <= 32'd0;
      err_q     <= 1'b0;
      plen_q    <= 6'd0;
      en_mask_q <= {NUM_MACHINES{1'b0}};
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      action_q  <= action_d;
      index_q   <= index_d;
      mindex_q  <= mindex_d;
      din_q     <= din_d;
      err_q     <= err_d;
      plen_q    <= plen_d;
      en_mask_q <= en_mask_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;
  assign err       = err_q;
  assign plen      = plen_q;
  assign en_mask   = en_mask_q;

endmodule
